// File: rtl/jpeg_pkg.sv
// jpeg_pkg: block-interface types and raster constants shared by the capture and output stages
package jpeg_pkg;
  localparam int BLOCK_SIZE = 8;
  localparam int HDMI_PIX_PER_BEAT = 2;
  localparam int HDMI_X_RES = 2160;
  localparam int HDMI_Y_RES = 1200;
  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;
  typedef struct packed {
    logic valid;
    logic sob;
    logic eob;
    logic sof;
    logic eof;
  } blk_side_t;
  typedef struct packed {
    logic valid;
    logic sob;
    logic eob;
    logic sof;
    logic eof;
    logic signed [HDMI_PIX_PER_BEAT-1:0][7:0] y;
    logic signed [HDMI_PIX_PER_BEAT-1:0][7:0] cr;
    logic signed [HDMI_PIX_PER_BEAT-1:0][7:0] cb;
  } blk_if_t;
endpackage

// File: rtl/stripe_buffer.sv
// stripe_buffer: two simple dual-port stripe RAMs selected per port, registered read
module stripe_buffer #(
  parameter int DEPTH = 64,
  parameter int W = 48,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_sel,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem_q [2][DEPTH];
  logic [W-1:0] rd_data_q;
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_sel][wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_sel][rd_addr];
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/hdmi_to_blocks.sv
// hdmi_to_blocks: captures raster lines into a ping-pong 8-line stripe buffer
// and replays each completed stripe in 8x8 block order with block sideband flags
module hdmi_to_blocks
  import jpeg_pkg::*;
#(
  parameter int N = HDMI_PIX_PER_BEAT,
  parameter int X_RES = HDMI_X_RES,
  parameter int Y_RES = HDMI_Y_RES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hdmi_v_sync,
  input  logic                    hdmi_h_sync,
  input  logic                    hdmi_data_valid,
  input  logic signed [N-1:0][7:0] hdmi_data_y,
  input  logic signed [N-1:0][7:0] hdmi_data_cr,
  input  logic signed [N-1:0][7:0] hdmi_data_cb,
  output logic                    blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                    blk_sob,
  output logic                    blk_eob,
  output logic                    blk_sof,
  output logic                    blk_eof,
  output logic                    err_overrun
);
  localparam int EPL = BLOCK_SIZE / N;
  localparam int LINE_W = X_RES / N;
  localparam int DEPTH = LINE_W * BLOCK_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int NSTRIPE = Y_RES / BLOCK_SIZE;
  localparam int SW = NSTRIPE > 1 ? $clog2(NSTRIPE) : 1;
  localparam int W = 24 * N;

  logic in_vld_q, in_vld_d, vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [W-1:0] in_data_q, in_data_d, ram_rd, out_data_q;
  logic armed_q, armed_d, wr_sel_q, wr_sel_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, cnt_q, cnt_d, rd_addr_q, rd_addr_d;
  logic [SW-1:0] stripe_q, stripe_d, tag_q, tag_d, ptag_q, ptag_d;
  rd_state_t state_q, state_d;
  logic rsel_q, rsel_d, psel_q, psel_d, pend_q, pend_d, err_q, err_d, rd_sel_q, rd_sel_d;
  blk_side_t side_a_q, side_a_d, side_b_q, side_o_q;
  logic vs_edge, wr_en, wr_last, rd_last, rd, handoff, unused_h_sync;
  logic [AW-1:0] e_w, l_w, b_w;

  assign unused_h_sync = hdmi_h_sync;
  assign vs_edge = vs_q & ~vs_prev_q;
  assign wr_en = armed_q & in_vld_q & ~vs_edge;
  assign wr_last = wr_addr_q == AW'(DEPTH - 1);
  assign handoff = wr_en & wr_last;
  assign rd = state_q == RD_READ;
  assign rd_last = cnt_q == AW'(DEPTH - 1);
  // cnt = {block, line, elem}; all divisors are powers of two
  assign e_w = cnt_q % AW'(EPL);
  assign l_w = (cnt_q / AW'(EPL)) % AW'(BLOCK_SIZE);
  assign b_w = cnt_q / AW'(EPL * BLOCK_SIZE);

  always_comb begin
    in_vld_d = hdmi_data_valid;
    vs_d = hdmi_v_sync;
    vs_prev_d = vs_q;
    in_data_d = {hdmi_data_y, hdmi_data_cr, hdmi_data_cb};
    armed_d = armed_q | vs_edge;
    wr_addr_d = vs_edge ? '0 : !wr_en ? wr_addr_q : wr_last ? '0 : wr_addr_q + 1'b1;
    stripe_d = vs_edge ? '0 : !handoff ? stripe_q : stripe_q == SW'(NSTRIPE - 1) ? '0 : stripe_q + 1'b1;
    wr_sel_d = wr_sel_q ^ handoff;
    err_d = err_q | (handoff & rd & pend_q);
    state_d = state_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    rsel_d = rsel_q;
    pend_d = pend_q;
    ptag_d = ptag_q;
    psel_d = psel_q;
    if (!rd) begin
      if (handoff) begin
        state_d = RD_READ;
        cnt_d = '0;
        tag_d = stripe_q;
        rsel_d = wr_sel_q;
      end
    end else if (rd_last) begin
      // a fresh handoff wins over a pending one; either keeps the reader busy without a gap
      cnt_d = '0;
      pend_d = 1'b0;
      tag_d = handoff ? stripe_q : ptag_q;
      rsel_d = handoff ? wr_sel_q : psel_q;
      state_d = handoff | pend_q ? RD_READ : RD_IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (handoff) begin
        pend_d = 1'b1;
        ptag_d = stripe_q;
        psel_d = wr_sel_q;
      end
    end
    rd_addr_d = l_w * AW'(LINE_W) + b_w * AW'(EPL) + e_w;
    rd_sel_d = rsel_q;
    side_a_d.valid = rd;
    side_a_d.sob = rd && l_w == '0 && e_w == '0;
    side_a_d.eob = rd && l_w == AW'(BLOCK_SIZE - 1) && e_w == AW'(EPL - 1);
    side_a_d.sof = side_a_d.sob && b_w == '0 && tag_q == '0;
    side_a_d.eof = side_a_d.eob && b_w == AW'(X_RES / BLOCK_SIZE - 1) && tag_q == SW'(NSTRIPE - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld_q <= 1'b0;
      vs_q <= 1'b0;
      vs_prev_q <= 1'b0;
      in_data_q <= '0;
      armed_q <= 1'b0;
      wr_sel_q <= 1'b0;
      wr_addr_q <= '0;
      stripe_q <= '0;
      state_q <= RD_IDLE;
      cnt_q <= '0;
      tag_q <= '0;
      rsel_q <= 1'b0;
      pend_q <= 1'b0;
      ptag_q <= '0;
      psel_q <= 1'b0;
      err_q <= 1'b0;
      rd_addr_q <= '0;
      rd_sel_q <= 1'b0;
      side_a_q <= '0;
      side_b_q <= '0;
      side_o_q <= '0;
      out_data_q <= '0;
    end else begin
      in_vld_q <= in_vld_d;
      vs_q <= vs_d;
      vs_prev_q <= vs_prev_d;
      in_data_q <= in_data_d;
      armed_q <= armed_d;
      wr_sel_q <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      stripe_q <= stripe_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      rsel_q <= rsel_d;
      pend_q <= pend_d;
      ptag_q <= ptag_d;
      psel_q <= psel_d;
      err_q <= err_d;
      rd_addr_q <= rd_addr_d;
      rd_sel_q <= rd_sel_d;
      side_a_q <= side_a_d;
      side_b_q <= side_a_q;
      side_o_q <= side_b_q;
      out_data_q <= ram_rd;
    end
  end

  stripe_buffer #(.DEPTH(DEPTH), .W(W)) u_buf (
    .clk(clk),
    .wr_en(wr_en),
    .wr_sel(wr_sel_q),
    .wr_addr(wr_addr_q),
    .wr_data(in_data_q),
    .rd_sel(rd_sel_q),
    .rd_addr(rd_addr_q),
    .rd_data(ram_rd)
  );

  assign blk_valid = side_o_q.valid;
  assign blk_sob = side_o_q.sob;
  assign blk_eob = side_o_q.eob;
  assign blk_sof = side_o_q.sof;
  assign blk_eof = side_o_q.eof;
  assign blk_data_y = out_data_q[3*8*N-1 -: 8*N];
  assign blk_data_cr = out_data_q[2*8*N-1 -: 8*N];
  assign blk_data_cb = out_data_q[8*N-1 -: 8*N];
  assign err_overrun = err_q;
endmodule

// File: tb/tb_hdmi_to_blocks.sv
// tb_hdmi_to_blocks: scoreboard bench; expected block beats are queued as stripes are driven
module tb_hdmi_to_blocks;
  localparam int N = 2;
  localparam int XR = 16;
  localparam int YR = 16;
  localparam int EPL = 8 / N;
  localparam int BPL = XR / N;
  localparam int SB = XR * 8 / N;
  localparam int NS = YR / 8;
  localparam int W = 8 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic hdmi_v_sync = 1'b0, hdmi_h_sync = 1'b0, hdmi_data_valid = 1'b0;
  logic signed [N-1:0][7:0] hdmi_data_y = '0, hdmi_data_cr = '0, hdmi_data_cb = '0;
  logic blk_valid, blk_sob, blk_eob, blk_sof, blk_eof, err_overrun;
  logic signed [N-1:0][7:0] blk_data_y, blk_data_cr, blk_data_cb;

  int checks = 0, errors = 0, cyc = 0, run = 0, vcount = 0, m_line = 0, v0 = 0;
  bit mon_en = 0, model_armed = 0;
  logic [4+3*W-1:0] exp_q[$];
  int t_q[$];

  hdmi_to_blocks #(.N(N), .X_RES(XR), .Y_RES(YR)) dut (
    .clk(clk), .rst_n(rst_n), .hdmi_v_sync(hdmi_v_sync), .hdmi_h_sync(hdmi_h_sync),
    .hdmi_data_valid(hdmi_data_valid), .hdmi_data_y(hdmi_data_y), .hdmi_data_cr(hdmi_data_cr),
    .hdmi_data_cb(hdmi_data_cb), .blk_valid(blk_valid), .blk_data_y(blk_data_y),
    .blk_data_cr(blk_data_cr), .blk_data_cb(blk_data_cb), .blk_sob(blk_sob), .blk_eob(blk_eob),
    .blk_sof(blk_sof), .blk_eof(blk_eof), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(int row, int x, int ch);
    logic [7:0] v = 8'((row * XR + x) & 255);
    return ch == 0 ? v : ch == 1 ? v ^ 8'hA5 : ~v;
  endfunction

  function automatic logic [53:0] outs();
    return {blk_valid, blk_sob, blk_eob, blk_sof, blk_eof, err_overrun, blk_data_y, blk_data_cr, blk_data_cb};
  endfunction

  task automatic push_stripe(int s);
    int tag = s % NS;
    for (int b = 0; b < XR / 8; b++)
      for (int l = 0; l < 8; l++)
        for (int e = 0; e < EPL; e++) begin
          logic [W-1:0] y, cr, cb;
          logic sob, eob;
          for (int i = 0; i < N; i++) begin
            y[8*i +: 8] = pix(8 * s + l, 8 * b + N * e + i, 0);
            cr[8*i +: 8] = pix(8 * s + l, 8 * b + N * e + i, 1);
            cb[8*i +: 8] = pix(8 * s + l, 8 * b + N * e + i, 2);
          end
          sob = l == 0 && e == 0;
          eob = l == 7 && e == EPL - 1;
          exp_q.push_back({sob, eob, sob && b == 0 && tag == 0, eob && b == XR / 8 - 1 && tag == NS - 1, y, cr, cb});
        end
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    hdmi_v_sync = 1'b1;
    hdmi_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    hdmi_v_sync = 1'b0;
    repeat (2) @(negedge clk);
    model_armed = 1;
    m_line = 0;
  endtask

  task automatic drive_lines(int n, int blank);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < BPL; c++) begin
        @(negedge clk);
        hdmi_data_valid = 1'b1;
        hdmi_h_sync = 1'b0;
        for (int i = 0; i < N; i++) begin
          hdmi_data_y[i] = pix(m_line, c * N + i, 0);
          hdmi_data_cr[i] = pix(m_line, c * N + i, 1);
          hdmi_data_cb[i] = pix(m_line, c * N + i, 2);
        end
      end
      if (model_armed && m_line % 8 == 7) begin
        push_stripe(m_line / 8);
        t_q.push_back(cyc + 1);
      end
      m_line++;
      repeat (blank) begin
        @(negedge clk);
        hdmi_data_valid = 1'b0;
        hdmi_h_sync = 1'b1;
      end
    end
    @(negedge clk);
    hdmi_data_valid = 1'b0;
    hdmi_h_sync = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (exp_q.size() != 0 || run != 0); i++) @(negedge clk);
    check("drain_exp", 64'(exp_q.size()), 0);
    check("drain_run", 64'(run), 0);
  endtask

  always @(negedge clk) begin
    if (blk_valid) vcount++;
    if (!mon_en) run = 0;
    else if (blk_valid) begin
      if (run == 0) begin
        check("stripe_expected", 64'(t_q.size() != 0), 1);
        if (t_q.size() != 0) check("latency", 64'(cyc - t_q.pop_front()), 4);
      end
      check("beat_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        check("beat", {blk_sob, blk_eob, blk_sof, blk_eof, blk_data_y, blk_data_cr, blk_data_cb}, exp_q.pop_front());
      run++;
    end else if (run > 0) begin
      check("run_len", 64'(run), SB);
      run = 0;
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #12 check("reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
    // beats before any v_sync edge are ignored
    v0 = vcount;
    drive_lines(16, 10);
    repeat (20) @(negedge clk);
    check("presync_valid", 64'(vcount - v0), 0);
    // ramp frame
    v0 = vcount;
    vsync_pulse();
    drive_lines(16, 10);
    drain();
    check("ramp_beats", 64'(vcount - v0), 2 * SB);
    // partial stripe abandoned by a new v_sync
    vsync_pulse();
    drive_lines(5, 10);
    v0 = vcount;
    vsync_pulse();
    drive_lines(16, 10);
    drain();
    check("partial_beats", 64'(vcount - v0), 2 * SB);
    // reset during a stripe readout
    vsync_pulse();
    drive_lines(8, 10);
    for (int i = 0; i < 100 && !blk_valid; i++) @(negedge clk);
    check("read_started", 64'(blk_valid), 1);
    repeat (20) @(negedge clk);
    #2;
    mon_en = 0;
    model_armed = 0;
    rst_n = 1'b0;
    #1 check("reset_mid_read", outs(), 0);
    exp_q.delete();
    t_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
    v0 = vcount;
    drive_lines(8, 10);
    repeat (20) @(negedge clk);
    check("no_out_before_vsync", 64'(vcount - v0), 0);
    vsync_pulse();
    drive_lines(8, 10);
    drain();
    check("post_reset_beats", 64'(vcount - v0), SB);
    // overrun: zero blanking plus forced back-to-back handoffs
    mon_en = 0;
    vsync_pulse();
    drive_lines(8, 0);
    repeat (3) @(negedge clk);
    check("err_before", 64'(err_overrun), 0);
    force dut.handoff = 1'b1;
    repeat (2) @(negedge clk);
    release dut.handoff;
    check("err_set", 64'(err_overrun), 1);
    repeat (300) @(negedge clk);
    check("err_sticky", 64'(err_overrun), 1);
    #2 rst_n = 1'b0;
    #1 check("err_cleared", 64'(err_overrun), 0);
    exp_q.delete();
    t_q.delete();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
